// File: rtl/tw_arbiter.sv
// Round-robin arbiter that grants one client at a time access to a three-wire
// engine, latching that client's operands and reporting completion or start timeout.
module tw_arbiter #(
    parameter int ADDR_BITS     = 9,
    parameter int DATA_BITS     = 16,
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                           in_clk,
    input  logic                           in_rst_n,
    input  logic [NUM_REQ-1:0]             in_req,
    input  logic [NUM_REQ-1:0]             in_req_r_w,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   in_req_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]   in_req_wr_data,
    output logic [NUM_REQ-1:0]             out_grant,
    output logic [NUM_REQ-1:0]             out_done,
    output logic                           out_err,
    output logic [DATA_BITS-1:0]           out_rd_data,
    output logic                           out_tw_r_w,
    output logic [ADDR_BITS-1:0]           out_tw_addr,
    output logic [DATA_BITS-1:0]           out_tw_wr_data,
    output logic                           out_tw_start,
    input  logic                           in_tw_busy,
    input  logic [DATA_BITS-1:0]           in_tw_rd_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [7:0] TIMEOUT_LAST = 8'(START_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [7:0]             cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   start_q, start_d;
    logic                   r_w_q, r_w_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [DATA_BITS-1:0]   wr_q, wr_d;
    logic [DATA_BITS-1:0]   rd_q, rd_d;

    logic                   found;
    logic [IDX_W-1:0]       pick;
    logic [IDX_W-1:0]       cand;
    logic [NUM_REQ-1:0]     pick_onehot;
    logic                   pick_r_w;
    logic [ADDR_BITS-1:0]   pick_addr;
    logic [DATA_BITS-1:0]   pick_wr;

    // Search starts one past the last grantee so every client gets a turn.
    always_comb begin
        found = 1'b0;
        pick  = ptr_q;
        cand  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr_q) + i) % NUM_REQ);
            if (!found && in_req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        pick_onehot = '0;
        pick_r_w    = 1'b0;
        pick_addr   = '0;
        pick_wr     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick == IDX_W'(k)) begin
                pick_onehot[k] = 1'b1;
                pick_r_w       = in_req_r_w[k];
                pick_addr      = in_req_addr[k*ADDR_BITS +: ADDR_BITS];
                pick_wr        = in_req_wr_data[k*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        start_d = start_q;
        r_w_d   = r_w_q;
        addr_d  = addr_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_LAUNCH;
                    grant_d = pick_onehot;
                    ptr_d   = pick;
                    r_w_d   = pick_r_w;
                    addr_d  = pick_addr;
                    wr_d    = pick_wr;
                    start_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_LAUNCH: begin
                if (in_tw_busy) begin
                    start_d = 1'b0;
                    state_d = ST_WAIT;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    start_d = 1'b0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_WAIT: begin
                if (!in_tw_busy) begin
                    rd_d    = in_tw_rd_data;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                start_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            r_w_q   <= 1'b0;
            addr_q  <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            start_q <= start_d;
            r_w_q   <= r_w_d;
            addr_q  <= addr_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
        end
    end

    // Completion signals are decoded from state so reset clears them immediately.
    assign out_done       = (state_q == ST_DONE) ? grant_q : '0;
    assign out_err        = (state_q == ST_DONE) && err_q;
    assign out_grant      = grant_q;
    assign out_rd_data    = rd_q;
    assign out_tw_r_w     = r_w_q;
    assign out_tw_addr    = addr_q;
    assign out_tw_wr_data = wr_q;
    assign out_tw_start   = start_q;

endmodule

// File: doc/tw_arbiter.md
TW_ARBITER -- requirements
Module: tw_arbiter

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 9, meaning the three-wire address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, meaning the three-wire data width.
REQ-003 SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (2..8).
REQ-004 SHALL have parameter START_TIMEOUT, default 16, meaning the maximum cycles to wait for the engine to go busy (1..255).
REQ-005 SHALL have port in_clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port in_rst_n, input, 1, the reset; asynchronous and active-low.
REQ-007 SHALL have port in_req, input, NUM_REQ, the per-client request level.
REQ-008 SHALL have port in_req_r_w, input, NUM_REQ, the per-client direction (1 = write, 0 = read).
REQ-009 SHALL have port in_req_addr, input, NUM_REQ*ADDR_BITS, the packed addresses; client k uses slice k.
REQ-010 SHALL have port in_req_wr_data, input, NUM_REQ*DATA_BITS, the packed write data; client k uses slice k.
REQ-011 SHALL have port out_grant, output, NUM_REQ, the one-hot grant, held for the whole transaction.
REQ-012 SHALL have port out_done, output, NUM_REQ, a one-cycle completion pulse to the granted client.
REQ-013 SHALL have port out_err, output, 1, a start-timeout flag, valid only with out_done.
REQ-014 SHALL have port out_rd_data, output, DATA_BITS, the read data, valid with out_done.
REQ-015 SHALL have ports out_tw_r_w (1), out_tw_addr (ADDR_BITS) and out_tw_wr_data (DATA_BITS), all outputs, carrying the latched operands to the three-wire engine.
REQ-016 SHALL have port out_tw_start, output, 1, the engine start level.
REQ-017 SHALL have port in_tw_busy, input, 1, high while the engine transaction is in progress.
REQ-018 SHALL have port in_tw_rd_data, input, DATA_BITS, the engine read result.

Function
REQ-019 SHALL implement the FSM states IDLE, LAUNCH, WAIT and DONE; any other encoding SHALL go to IDLE.
REQ-020 IDLE with any in_req bit set SHALL take one cycle to reach LAUNCH, registering the following:
- the grant, chosen round-robin starting at the index after the last grantee (wrapping at NUM_REQ-1);
- the grantee's r_w, addr and wr_data slices into out_tw_*;
- out_tw_start = 1;
- the timeout counter cleared.
REQ-021 in_req SHALL be sampled only in IDLE; operands SHALL be latched only at grant, so a client's operand changes after grant have no effect.
REQ-022 LAUNCH SHALL hold out_tw_start high until in_tw_busy is sampled high, then drop out_tw_start and go to WAIT.
REQ-023 If in_tw_busy stays low for START_TIMEOUT LAUNCH cycles, the block SHALL drop out_tw_start, set the error flag and go to DONE.
REQ-024 WAIT SHALL remain until in_tw_busy is sampled low, then register in_tw_rd_data into out_rd_data, clear the error flag and go to DONE.
REQ-025 DONE SHALL last exactly one cycle with out_done = out_grant and out_err = the error flag; the next state SHALL be IDLE with out_grant = 0.
REQ-026 out_done and out_err SHALL be 0 in every state except DONE.
REQ-027 A client dropping in_req after grant SHALL NOT abort the transaction; out_done still pulses.
REQ-028 A request still high in the IDLE cycle after its DONE SHALL be treated as a new request, subject to round-robin.
REQ-029 For a write, out_rd_data SHALL be updated with in_tw_rd_data anyway; clients ignore it.
REQ-030 The round-robin pointer SHALL update only at grant.
REQ-031 Minimum turnaround SHALL be 4 cycles (IDLE, LAUNCH, WAIT, DONE), plus engine time.

Reset
REQ-032 While in_rst_n = 0, the block SHALL immediately force:
- state = IDLE;
- out_grant, out_done, out_err, out_tw_start, out_tw_r_w, out_tw_addr, out_tw_wr_data and out_rd_data = 0;
- the timeout counter = 0;
- the pointer = NUM_REQ-1, so client 0 wins first.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no out_done pulse.

Verification
REQ-034 Reset: drive in_rst_n low with in_req = 4'b1111 -> all outputs 0; after release, out_grant = 4'b0001 on the second edge.
REQ-035 Single read: client 2 requests with r_w = 0 and addr = 9'h1A5; the engine model raises busy 3 cycles after start, lowers it 120 cycles later, with rd_data = 16'hBEEF ->
- out_grant = 4'b0100 and out_tw_addr = 9'h1A5;
- start is high for 3 cycles;
- out_done = 4'b0100 for one cycle with out_rd_data = 16'hBEEF and out_err = 0.
REQ-036 Fairness: in_req = 4'b1111 held constant -> grant order 0, 1, 2, 3, 0, with no client granted twice in a row.
REQ-037 Timeout: busy is never raised -> out_tw_start is high for exactly 16 cycles, followed by one DONE cycle with out_err = 1, then IDLE.
REQ-038 Abort: assert reset during WAIT -> outputs are 0 within the same cycle and no out_done pulse occurs; after release, a new request completes normally.
REQ-039 Dropped request: client 1 drops in_req in WAIT -> out_done = 4'b0010 still pulses once.
